// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// Ring-oscillator frequency meter: counts osc_in rising edges over a gate window.
// Define FREQ_METER_SATURATE_EN for a saturating counter with overflow flag.
module freq_meter #(
    parameter int GATE_LOG2 = 10,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] result,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GATE,
        DONE
    } state_t;

    localparam logic [GATE_LOG2:0] TMR_TC = {1'b0, {GATE_LOG2{1'b1}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               w_edge;
    logic [GATE_LOG2:0] r_tmr;
    logic               w_tc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   r_result;

    // osc_in is asynchronous; s3 only exists to form the edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= osc_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3;
    assign w_tc   = (r_tmr == TMR_TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        valid       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                busy        = 1'b1;
                w_state_nxt = GATE;
            end
            GATE: begin
                busy = 1'b1;
                if (w_tc) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                valid       = 1'b1;
                w_state_nxt = cont ? ARM : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == GATE && w_edge) begin
`ifdef FREQ_METER_SATURATE_EN
            if (!(&r_cnt)) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`else
            w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        end
    end

    // result is captured on the last gate cycle so it is already new while valid is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_tmr    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ARM: begin
                    r_cnt <= '0;
                    r_tmr <= '0;
                end
                GATE: begin
                    r_cnt <= w_cnt_nxt;
                    r_tmr <= w_tc ? '0 : r_tmr + 1'b1;
                    if (w_tc) begin
                        r_result <= w_cnt_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

`ifdef FREQ_METER_SATURATE_EN
    logic r_ovf_int;
    logic w_ovf_nxt;
    logic r_ovf;

    always_comb begin
        w_ovf_nxt = r_ovf_int;
        if (r_state == GATE && w_edge && (&r_cnt)) begin
            w_ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_int <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (r_state == ARM) begin
            r_ovf_int <= 1'b0;
        end else if (r_state == GATE) begin
            r_ovf_int <= w_ovf_nxt;
            if (w_tc) begin
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
// Bench for freq_meter: random osc patterns checked against an edge-count model.
// Covers reset, latency, overflow, ignored start, continuous mode, mid-gate reset.
module tb_freq_meter;

    localparam int GL  = 4;
    localparam int CW  = 3;
    localparam int WIN = 1 << GL;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          osc_in = 1'b0;
    logic          start  = 1'b0;
    logic          cont   = 1'b0;
    logic          busy;
    logic          valid;
    logic          ovf;
    logic [CW-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    freq_meter #(
        .GATE_LOG2(GL),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .osc_in(osc_in),
        .start (start),
        .cont  (cont),
        .busy  (busy),
        .valid (valid),
        .result(result),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Count rising transitions in the sampled window, then apply counter limits
    function automatic void model(input logic [WIN-1:0] pat, input logic prev,
                                  output logic [CW-1:0] r, output logic o);
        int   n;
        logic last;
        n    = 0;
        last = prev;
        for (int i = 0; i < WIN; i++) begin
            if (pat[i] && !last) n++;
            last = pat[i];
        end
`ifdef FREQ_METER_SATURATE_EN
        if (n > (1 << CW) - 1) begin
            r = '1;
            o = 1'b1;
        end else begin
            r = CW'(n);
            o = 1'b0;
        end
`else
        r = CW'(n % (1 << CW));
        o = 1'b0;
`endif
    endfunction

    function automatic logic [WIN-1:0] period4();
        logic [WIN-1:0] p;
        for (int i = 0; i < WIN; i++) p[i] = ((i % 4) >= 2);
        return p;
    endfunction

    // Drive one measurement; pat[i] is the osc_in value seen by the i-th clock from start
    task automatic run_window(input logic [WIN-1:0] pat, input int restart_at,
                              output int nvalid, output int vcyc,
                              output logic [CW-1:0] vres, output logic vovf,
                              output logic busy_first, output logic busy_end);
        nvalid     = 0;
        vcyc       = -1;
        vres       = '0;
        vovf       = 1'b0;
        busy_first = 1'b0;
        repeat (3) @(negedge clk);
        start  = 1'b1;
        osc_in = pat[0];
        for (int m = 1; m <= 19; m++) begin
            @(negedge clk);
            if (m == 1) busy_first = busy;
            if (valid) begin
                nvalid++;
                if (vcyc < 0) begin
                    vcyc = m;
                    vres = result;
                    vovf = ovf;
                end
            end
            start = (m == restart_at);
            if (m < WIN) osc_in = pat[m];
        end
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_valid: got %b want 0", valid);
        end
        n_cmp++;
        if (result !== '0) begin
            n_bad++;
            $display("FAIL rst_result: got %0d want 0", result);
        end
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ovf: got %b want 0", ovf);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_window(input string name, input logic [WIN-1:0] pat,
                                input int restart_at);
        int            nv;
        int            vc;
        logic [CW-1:0] vr;
        logic          vo;
        logic          bf;
        logic          be;
        logic [CW-1:0] er;
        logic          eo;
        model(pat, osc_in, er, eo);
        run_window(pat, restart_at, nv, vc, vr, vo, bf, be);
        n_cmp++;
        if (nv !== 1) begin
            n_bad++;
            $display("FAIL %s_npulse: got %0d want 1", name, nv);
        end
        n_cmp++;
        if (vc !== WIN + 2) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, vc, WIN + 2);
        end
        n_cmp++;
        if (vr !== er) begin
            n_bad++;
            $display("FAIL %s_result: got %0d want %0d", name, vr, er);
        end
        n_cmp++;
        if (vo !== eo) begin
            n_bad++;
            $display("FAIL %s_ovf: got %b want %b", name, vo, eo);
        end
        n_cmp++;
        if (bf !== 1'b1 || be !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy: got first=%b end=%b want 1/0", name, bf, be);
        end
    endtask

    task automatic test_period4();
        osc_in = 1'b0;
        check_window("p4", period4(), -1);
    endtask

    task automatic test_const();
        osc_in = 1'b0;
        check_window("low", '0, -1);
        osc_in = 1'b1;
        check_window("high", '1, -1);
    endtask

    task automatic test_overflow();
        logic [WIN-1:0] p;
        for (int i = 0; i < WIN; i++) p[i] = (i % 2 == 1);
        osc_in = 1'b0;
        check_window("ovf", p, -1);
    endtask

    task automatic test_start_ignored();
        check_window("restart", WIN'($urandom), 6);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            check_window("rand", WIN'($urandom), -1);
        end
    endtask

    task automatic test_back_to_back();
        check_window("b2b_a", WIN'($urandom), -1);
        check_window("b2b_b", WIN'($urandom), -1);
    endtask

    task automatic test_cont();
        int            t[$];
        logic [CW-1:0] r[$];
        logic [CW-1:0] er;
        logic          eo;
        model(period4(), 1'b0, er, eo);
        cont = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (valid) begin
                t.push_back(c);
                r.push_back(result);
                if (t.size() == 3) cont = 1'b0;
            end
            start  = (c == 2);
            osc_in = ((c % 4) >= 2);
        end
        n_cmp++;
        if (t.size() !== 3) begin
            n_bad++;
            $display("FAIL cont_npulse: got %0d want 3", t.size());
        end else begin
            n_cmp++;
            if (t[0] !== 2 + WIN + 2) begin
                n_bad++;
                $display("FAIL cont_first: got %0d want %0d", t[0], WIN + 4);
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (t[i] - t[i-1] !== WIN + 2) begin
                    n_bad++;
                    $display("FAIL cont_period: got %0d want %0d", t[i] - t[i-1], WIN + 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (r[i] !== er) begin
                    n_bad++;
                    $display("FAIL cont_result: got %0d want %0d", r[i], er);
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_stop: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_gate();
        int nv;
        check_window("pre_rst", period4(), -1);
        cont = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            osc_in = ~osc_in;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, valid, result, ovf} !== '0) begin
            n_bad++;
            $display("FAIL midrst_out: got busy=%b valid=%b result=%0d ovf=%b want 0",
                     busy, valid, result, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nv    = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            osc_in = ~osc_in;
            if (valid || busy) nv++;
        end
        n_cmp++;
        if (nv !== 0) begin
            n_bad++;
            $display("FAIL midrst_idle: got %0d active cycles want 0", nv);
        end
        cont = 1'b0;
        check_window("post_rst", WIN'($urandom), -1);
    endtask

    initial begin
        test_reset();
        test_period4();
        test_const();
        test_overflow();
        test_start_ignored();
        test_random();
        test_back_to_back();
        test_cont();
        test_reset_mid_gate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_LOG2, default 10, meaning the gate window is 2^GATE_LOG2 clk cycles.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the edge counter and of the result.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port osc_in, input, 1, the divided ring-oscillator output, asynchronous to clk.
REQ-006 SHALL have port start, input, 1, a request to begin one measurement, sampled in IDLE only.
REQ-007 SHALL have port cont, input, 1, continuous mode: re-arm automatically after DONE.
REQ-008 SHALL have port busy, output, 1, high while the FSM is in ARM, GATE or DONE.
REQ-009 SHALL have port valid, output, 1, a one-cycle pulse marking a new result.
REQ-010 SHALL have port result, output, CNT_W, the osc_in rising-edge count from the last gate window, held until the next DONE.
REQ-011 SHALL have port ovf, output, 1, the overflow flag for the last result.

Function
REQ-012 SHALL resynchronise osc_in through two flops (s1, s2) and then a third flop s3; edge strobe = s2 & ~s3.
REQ-013 SHALL implement FSM states IDLE, ARM, GATE, DONE.
REQ-014 SHALL move IDLE->ARM on the cycle after start=1 is sampled; start SHALL be ignored in every other state.
REQ-015 ARM SHALL last exactly 1 cycle, clear the edge counter, gate timer and internal overflow, then move to GATE.
REQ-016 GATE SHALL last exactly 2^GATE_LOG2 cycles and increment the edge counter on every cycle in which the edge strobe is 1.
REQ-017 DONE SHALL last 1 cycle, load result and ovf from the counter, and assert valid for that cycle only.
REQ-018 From DONE the FSM SHALL go to ARM if cont=1, else to IDLE.
REQ-019 Latency: start sampled at cycle N gives busy=1 from N+1 and valid=1 at cycle N+2+2^GATE_LOG2.
REQ-020 SHALL count at most one edge per clk cycle; osc_in frequencies above clk/2 are out of range and give an undefined count.
REQ-021 The gate timer SHALL be GATE_LOG2+1 bits wide and SHALL wrap only after reaching terminal count.

Reset
REQ-022 rst_n low SHALL immediately force the state to IDLE, all synchroniser flops and counters to 0, result=0, ovf=0, valid=0 and busy=0.
REQ-023 A reset during GATE SHALL discard the partial count; no valid pulse is produced for the aborted window.
REQ-024 After release, the first measurement SHALL require a new start, even if cont=1.

Configuration
REQ-025 The macro FREQ_METER_SATURATE_EN SHALL select the counter overflow behaviour.
REQ-026 With FREQ_METER_SATURATE_EN defined, the counter SHALL stick at 2^CNT_W-1, and a further edge SHALL set internal overflow, which is copied to ovf at DONE.
REQ-027 Without FREQ_METER_SATURATE_EN, the counter SHALL wrap modulo 2^CNT_W and ovf SHALL be constant 0.

Verification
REQ-028 GATE_LOG2=4, osc_in period 4 clk, start pulse at cycle N -> valid at N+18, result=4, ovf=0.
REQ-029 GATE_LOG2=4, osc_in held at 0 or held at 1 -> result=0, valid pulses once, busy low at N+19.
REQ-030 GATE_LOG2=4, CNT_W=3, osc_in period 2 clk (8 edges) -> with macro: result=7, ovf=1; without macro: result=0, ovf=0.
REQ-031 start pulsed again during GATE -> ignored: exactly one valid pulse; cont=1 -> valid pulses repeat every 2^GATE_LOG2+2 cycles with a constant result.
REQ-032 rst_n asserted mid-GATE -> outputs go to 0 at once, no valid pulse, FSM stays in IDLE until the next start.
